// File: rtl/sram_bank_arbiter.sv
// Per-bank round-robin arbiter sharing a multi-bank scratchpad among several requesters.
// One requester gets strict priority, limited to MAX_BURST grants in a row while others wait.
module sram_bank_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned ROW_W     = 8,
  parameter int unsigned PRIO_REQ  = 0,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0]     rsp_rdata,
  output logic [NUM_BANKS-1:0]          bank_en,
  output logic [NUM_BANKS-1:0]          bank_we,
  output logic [NUM_BANKS*ROW_W-1:0]    bank_addr,
  output logic [NUM_BANKS*DATA_W-1:0]   bank_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0]   bank_rdata,
  output logic [31:0]                   conflict_cnt
);

  localparam int unsigned BankW = $clog2(NUM_BANKS);
  localparam int unsigned ReqW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned RunW  = ($clog2(MAX_BURST + 1) < 3) ? 3 : $clog2(MAX_BURST + 1);

  logic [NUM_REQ-1:0] valid_eff;
  logic [NUM_REQ-1:0] cand   [NUM_BANKS];
  logic [NUM_REQ-1:0] others [NUM_BANKS];
  logic               gnt_valid [NUM_BANKS];
  logic [ReqW-1:0]    gnt_idx   [NUM_BANKS];

  logic [RunW-1:0]    prio_run_q [NUM_BANKS];
  logic [RunW-1:0]    prio_run_d [NUM_BANKS];
  logic [ReqW-1:0]    rr_ptr_q   [NUM_BANKS];
  logic [ReqW-1:0]    rr_ptr_d   [NUM_BANKS];
  logic               tag_valid_q [NUM_BANKS];
  logic               tag_valid_d [NUM_BANKS];
  logic [ReqW-1:0]    tag_req_q   [NUM_BANKS];
  logic [ReqW-1:0]    tag_req_d   [NUM_BANKS];
  logic [31:0]        conflict_q;
  logic [31:0]        conflict_d;

  // Keep every bank output idle while reset is held, even if requesters are driving.
  assign valid_eff = rst_n ? req_valid : '0;

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      cand[b]      = '0;
      gnt_valid[b] = 1'b0;
      gnt_idx[b]   = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        cand[b][r] = valid_eff[r] && (req_addr[r*ADDR_W +: BankW] == BankW'(b));
      end
      others[b]           = cand[b];
      others[b][PRIO_REQ] = 1'b0;
      if (cand[b][PRIO_REQ] && ((prio_run_q[b] < RunW'(MAX_BURST)) || (others[b] == '0))) begin
        gnt_valid[b] = 1'b1;
        gnt_idx[b]   = ReqW'(PRIO_REQ);
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!gnt_valid[b] && others[b][(int'(rr_ptr_q[b]) + i) % NUM_REQ]) begin
            gnt_valid[b] = 1'b1;
            gnt_idx[b]   = ReqW'((int'(rr_ptr_q[b]) + i) % NUM_REQ);
          end
        end
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    bank_en    = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      prio_run_d[b]  = prio_run_q[b];
      rr_ptr_d[b]    = rr_ptr_q[b];
      tag_valid_d[b] = 1'b0;
      tag_req_d[b]   = gnt_idx[b];
      if (gnt_valid[b]) begin
        req_ready[gnt_idx[b]]             = 1'b1;
        bank_en[b]                        = 1'b1;
        bank_we[b]                        = req_we[gnt_idx[b]];
        bank_addr[b*ROW_W +: ROW_W]       = req_addr[int'(gnt_idx[b])*ADDR_W + BankW +: ROW_W];
        bank_wdata[b*DATA_W +: DATA_W]    = req_wdata[int'(gnt_idx[b])*DATA_W +: DATA_W];
        tag_valid_d[b]                    = !req_we[gnt_idx[b]];
      end
      if (gnt_valid[b] && (gnt_idx[b] == ReqW'(PRIO_REQ))) begin
        if ((others[b] != '0) && (prio_run_q[b] != '1)) begin
          prio_run_d[b] = prio_run_q[b] + 1'b1;
        end
      end else if (gnt_valid[b]) begin
        prio_run_d[b] = '0;
        // Next search starts after the winner, never parked on the priority requester.
        if (((int'(gnt_idx[b]) + 1) % NUM_REQ) == PRIO_REQ) begin
          rr_ptr_d[b] = ReqW'((int'(gnt_idx[b]) + 2) % NUM_REQ);
        end else begin
          rr_ptr_d[b] = ReqW'((int'(gnt_idx[b]) + 1) % NUM_REQ);
        end
      end else if (!cand[b][PRIO_REQ]) begin
        prio_run_d[b] = '0;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (tag_valid_q[b]) begin
        rsp_valid[tag_req_q[b]]                         = 1'b1;
        rsp_rdata[int'(tag_req_q[b])*DATA_W +: DATA_W]  = bank_rdata[b*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    conflict_d = conflict_q;
    if (((valid_eff & ~req_ready) != '0) && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_d = conflict_q + 32'd1;
    end
  end

  assign conflict_cnt = conflict_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        prio_run_q[b]  <= '0;
        rr_ptr_q[b]    <= '0;
        tag_valid_q[b] <= 1'b0;
        tag_req_q[b]   <= '0;
      end
      conflict_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        prio_run_q[b]  <= prio_run_d[b];
        rr_ptr_q[b]    <= rr_ptr_d[b];
        tag_valid_q[b] <= tag_valid_d[b];
        tag_req_q[b]   <= tag_req_d[b];
      end
      conflict_q <= conflict_d;
    end
  end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter with a behavioural write-first SRAM per bank.
module tb_sram_bank_arbiter;

  localparam int NR = 4;
  localparam int NB = 4;
  localparam int DW = 256;
  localparam int AW = 20;
  localparam int RW = 8;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    rsp_valid;
  logic [NR*DW-1:0] rsp_rdata;
  logic [NB-1:0]    bank_en;
  logic [NB-1:0]    bank_we;
  logic [NB*RW-1:0] bank_addr;
  logic [NB*DW-1:0] bank_wdata;
  logic [NB*DW-1:0] bank_rdata;
  logic [31:0]      conflict_cnt;

  int n_checks;
  int n_fail;

  sram_bank_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .bank_en      (bank_en),
    .bank_we      (bank_we),
    .bank_addr    (bank_addr),
    .bank_wdata   (bank_wdata),
    .bank_rdata   (bank_rdata),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: registered read, write-first, plus a preload port for the bench.
  logic [DW-1:0] mem [NB][256];
  logic [DW-1:0] rdata_q [NB];
  logic          pl_we;
  int            pl_bank;
  int            pl_row;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) mem[pl_bank][pl_row] <= pl_data;
    for (int b = 0; b < NB; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) begin
          mem[b][bank_addr[b*RW +: RW]] <= bank_wdata[b*DW +: DW];
          rdata_q[b] <= bank_wdata[b*DW +: DW];
        end else begin
          rdata_q[b] <= mem[b][bank_addr[b*RW +: RW]];
        end
      end
    end
  end

  always_comb begin
    bank_rdata = '0;
    for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = rdata_q[b];
  end

  task automatic preload(input int b, input int row, input logic [DW-1:0] d);
    pl_we = 1'b1; pl_bank = b; pl_row = row; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic set_req(input int r, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[r]          = 1'b1;
    req_we[r]             = we;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_reqs();
    req_valid = '1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_checks++;
    if (bank_en !== 4'b0 || bank_addr !== '0) begin
      n_fail++; $display("FAIL reset_bank: en %b addr %h want 0", bank_en, bank_addr);
    end
    n_checks++;
    if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL reset_rsp: got %b want 0000", rsp_valid); end
    n_checks++;
    if (conflict_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_conflict: got %0d want 0", conflict_cnt); end
    clear_reqs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    do_reset();
    preload(1, 4, 256'hAB);
    set_req(1, 1'b0, 20'h11, '0);
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready: got %b want 0010", req_ready); end
    n_checks++;
    if (bank_en !== 4'b0010 || bank_we !== 4'b0 || bank_addr[1*RW +: RW] !== 8'd4) begin
      n_fail++; $display("FAIL single_bank: en %b we %b row %0d want 0010 0000 4",
                         bank_en, bank_we, bank_addr[1*RW +: RW]);
    end
    @(negedge clk);
    clear_reqs();
    n_checks++;
    if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 0010", rsp_valid); end
    n_checks++;
    if (rsp_rdata[1*DW +: DW] !== 256'hAB) begin
      n_fail++; $display("FAIL single_rdata: got %h want ab", rsp_rdata[1*DW +: DW]);
    end
    n_checks++;
    if (conflict_cnt !== 32'd0) begin n_fail++; $display("FAIL single_conflict: got %0d want 0", conflict_cnt); end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL single_rsp_once: got %b want 0000", rsp_valid); end
  endtask

  task automatic test_parallel_banks();
    do_reset();
    for (int b = 0; b < NB; b++) preload(b, 0, DW'(32'h100 + b));
    for (int r = 0; r < NR; r++) set_req(r, 1'b0, AW'(r), '0);
    #1;
    n_checks++;
    if (req_ready !== 4'b1111) begin n_fail++; $display("FAIL par_ready: got %b want 1111", req_ready); end
    @(negedge clk);
    clear_reqs();
    n_checks++;
    if (rsp_valid !== 4'b1111) begin n_fail++; $display("FAIL par_rsp_valid: got %b want 1111", rsp_valid); end
    for (int r = 0; r < NR; r++) begin
      n_checks++;
      if (rsp_rdata[r*DW +: DW] !== DW'(32'h100 + r)) begin
        n_fail++; $display("FAIL par_rdata%0d: got %h want %h", r, rsp_rdata[r*DW +: DW], 32'h100 + r);
      end
    end
    n_checks++;
    if (conflict_cnt !== 32'd0) begin n_fail++; $display("FAIL par_conflict: got %0d want 0", conflict_cnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy [6];
    exp_rdy = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    set_req(1, 1'b0, 20'h2, '0);
    set_req(2, 1'b0, 20'h6, '0);
    set_req(3, 1'b0, 20'hA, '0);
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (req_ready !== exp_rdy[i]) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, exp_rdy[i]);
      end
      n_checks++;
      if (conflict_cnt !== 32'(i)) begin
        n_fail++; $display("FAIL rr_conflict%0d: got %0d want %0d", i, conflict_cnt, i);
      end
      @(negedge clk);
    end
    clear_reqs();
    n_checks++;
    if (conflict_cnt !== 32'd6) begin n_fail++; $display("FAIL rr_conflict_end: got %0d want 6", conflict_cnt); end
  endtask

  task automatic test_bounded_priority();
    logic [3:0] exp_rdy [10];
    exp_rdy = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100,
                4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100};
    do_reset();
    set_req(0, 1'b0, 20'h0, '0);
    set_req(2, 1'b0, 20'h4, '0);
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (req_ready !== exp_rdy[i]) begin
        n_fail++; $display("FAIL prio_grant%0d: got %b want %b", i, req_ready, exp_rdy[i]);
      end
      @(negedge clk);
    end
    clear_reqs();
  endtask

  task automatic test_write_read();
    do_reset();
    set_req(3, 1'b1, 20'h20, 256'h5A);
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wr_ready: got %b want 1000", req_ready); end
    n_checks++;
    if (bank_en !== 4'b0001 || bank_we !== 4'b0001 || bank_addr[RW-1:0] !== 8'd8
        || bank_wdata[DW-1:0] !== 256'h5A) begin
      n_fail++; $display("FAIL wr_bank: en %b we %b row %0d data %h want 0001 0001 8 5a",
                         bank_en, bank_we, bank_addr[RW-1:0], bank_wdata[DW-1:0]);
    end
    @(negedge clk);
    set_req(3, 1'b0, 20'h20, '0);
    #1;
    n_checks++;
    if (bank_en !== 4'b0001 || bank_we !== 4'b0000) begin
      n_fail++; $display("FAIL rd_bank: en %b we %b want 0001 0000", bank_en, bank_we);
    end
    n_checks++;
    if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL wr_no_rsp: got %b want 0000", rsp_valid); end
    @(negedge clk);
    clear_reqs();
    n_checks++;
    if (rsp_valid !== 4'b1000 || rsp_rdata[3*DW +: DW] !== 256'h5A) begin
      n_fail++; $display("FAIL raw_rdata: valid %b data %h want 1000 5a", rsp_valid, rsp_rdata[3*DW +: DW]);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    // One contended cycle on bank 2 moves its pointer past requester 1.
    set_req(1, 1'b0, 20'h2, '0);
    set_req(2, 1'b0, 20'h6, '0);
    @(negedge clk);
    clear_reqs();
    n_checks++;
    if (conflict_cnt !== 32'd1) begin n_fail++; $display("FAIL mid_conflict_pre: got %0d want 1", conflict_cnt); end
    set_req(1, 1'b0, 20'h1, '0);
    @(negedge clk);
    clear_reqs();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0 || rsp_rdata !== '0) begin
      n_fail++; $display("FAIL mid_rsp_dropped: valid %b want 0000", rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL mid_rsp_after: got %b want 0000", rsp_valid); end
    n_checks++;
    if (conflict_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_conflict: got %0d want 0", conflict_cnt); end
    set_req(1, 1'b0, 20'h2, '0);
    set_req(2, 1'b0, 20'h6, '0);
    set_req(3, 1'b0, 20'hA, '0);
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_rr_restart: got %b want 0010", req_ready); end
    @(negedge clk);
    clear_reqs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pl_we    = 1'b0;
    pl_bank  = 0;
    pl_row   = 0;
    pl_data  = '0;
    rst_n    = 1'b1;
    clear_reqs();
    #2;
    test_reset();
    test_single_read();
    test_parallel_banks();
    test_round_robin();
    test_bounded_priority();
    test_write_read();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bank_arbiter.md
Name: sram_bank_arbiter

Overview:
Shares the TPC's multi-bank scratchpad SRAM among four requesters: 0 = MXU, 1 = VPU, 2 = DMA, 3 = NoC RX/TX. Each bank has an independent round-robin arbiter, so requesters targeting different banks proceed in parallel. A configurable priority requester (the MXU by default) gets bounded strict priority. Read data returns to the granted requester with fixed latency, and a conflict counter supports performance debug.

Parameters:
- NUM_REQ, 4, number of requesters
- NUM_BANKS, 4, number of SRAM banks (power of 2)
- DATA_W, 256, word width (equals SRAM_WIDTH)
- ADDR_W, 20, requester word-address width
- ROW_W, 8, bank row-address width (log2 of SRAM_DEPTH=256)
- PRIO_REQ, 0, index of the strict-priority requester
- MAX_BURST, 4, maximum consecutive priority grants to one bank while others wait

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant; a transfer occurs when valid&ready
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  word address, requester r at [r*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  write data
- rsp_valid  out  NUM_REQ  read data valid (reads only)
- rsp_rdata  out  NUM_REQ*DATA_W  read data
- bank_en  out  NUM_BANKS  bank access enable
- bank_we  out  NUM_BANKS  bank write enable
- bank_addr  out  NUM_BANKS*ROW_W  bank row
- bank_wdata  out  NUM_BANKS*DATA_W  bank write data
- bank_rdata  in  NUM_BANKS*DATA_W  bank read data, valid 1 cycle after bank_en&~bank_we
- conflict_cnt  out  32  cycles in which at least one valid request was not granted

Behaviour:
- Address map: bank = addr[log2(NUM_BANKS)-1:0]; row = addr[log2(NUM_BANKS) +: ROW_W]; higher bits are ignored (no error).
- Arbitration is combinational within the cycle. For each bank b, the candidates are requesters with req_valid=1 and target bank b. At most one grant per bank. A requester targets exactly one bank, so it receives at most one grant.
- Priority rule: if PRIO_REQ is a candidate and prio_run[b] < MAX_BURST, or PRIO_REQ is the only candidate, grant PRIO_REQ. Otherwise grant round-robin among non-priority candidates starting at rr_ptr[b]. If no such candidate exists, fall back to PRIO_REQ.
- prio_run[b] (3+ bits, saturating) increments on each PRIO_REQ grant to bank b while another candidate waits. It clears on any non-priority grant to b, or when PRIO_REQ does not request b.
- rr_ptr[b] updates only on a non-priority grant, to (granted index + 1) mod NUM_REQ, skipping PRIO_REQ.
- req_ready[r] = grant. req_ready does not depend on rsp state: no backpressure on responses, and requesters must accept rsp_valid.
- Bank drive: bank_en[b]=1 when granted. bank_we, bank_addr and bank_wdata come from the winner. When idle: bank_en=0, bank_we=0, bank_addr=0, bank_wdata=0.
- Read return: a registered tag (valid, requester, bank) per bank. In the cycle after a read grant, rsp_valid[r]=1 and rsp_rdata[r]=bank_rdata[bank]. Read latency is therefore 1 cycle from the handshake. Writes produce no response.
- Pipelining: back-to-back reads from one requester are allowed every cycle. A requester may have reads to different banks returned in consecutive cycles, never two in the same cycle.
- Read after a write to the same address in consecutive cycles returns the new data (the bank is write-first; the arbiter adds no hazard logic).
- conflict_cnt increments by 1 in any cycle where some req_valid[r]=1 and req_ready[r]=0. It saturates at 0xFFFFFFFF.
- Reset (async, any time): rr_ptr=0, prio_run=0, tags cleared, rsp_valid=0, rsp_rdata=0, conflict_cnt=0, and all bank outputs 0. An in-flight read is dropped and never responded to.
- No valid requests: all outputs idle and no state changes except prio_run clearing.

Test Plan:
- Single read: preload bank1 row4 = 0xAB, VPU reads addr 0x11 → ready in the same cycle, rsp_valid[1]=1 with 0xAB exactly one cycle later, bank_addr[1]=4, conflict_cnt=0.
- Parallel banks: all four requesters read addrs 0x0, 0x1, 0x2, 0x3 simultaneously → all four ready in the same cycle, four responses the next cycle, conflict_cnt=0.
- Round-robin fairness: VPU, DMA and NoC hold continuous reads to bank2 with the MXU idle → grant order 1,2,3,1,2,3; each waits exactly 2 cycles between grants; conflict_cnt +1 per cycle.
- Bounded priority: MXU and DMA continuously request bank0, MAX_BURST=4 → grants MXU×4, DMA×1, repeating; DMA is never starved beyond 4 cycles.
- Write then read: NoC writes 0x5A to addr 0x20, then reads 0x20 the next cycle → rsp_rdata[3]=0x5A; bank_we[0]=1 only in the write cycle.
- Reset mid-read: assert rst_n=0 in the cycle after a read grant → rsp_valid stays 0; after release, conflict_cnt=0 and rr_ptr restarts at requester 1.
